// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// fixed WIDTH-cycle latency, with a handshake-style done flag held while enabled.
module shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mult_enable,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 mult_done,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   state_e            state_q,   state_d;
   logic [PW-1:0]     mcand_q,   mcand_d;
   logic [WIDTH-1:0]  mplier_q,  mplier_d;
   logic [PW-1:0]     acc_q,     acc_d;
   logic [CW-1:0]     count_q,   count_d;
   logic [PW-1:0]     product_q, product_d;
   logic              done_q,    done_d;
   logic              busy_q,    busy_d;
   logic [PW-1:0]     acc_sum_s;

   // Next-state and datapath computation for all registers.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      done_d    = done_q;
      busy_d    = busy_q;

      // Partial product for this iteration; the top half of mcand absorbs all shifts.
      if (mplier_q[0]) begin
         acc_sum_s = acc_q + mcand_q;
      end else begin
         acc_sum_s = acc_q;
      end

      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (mult_enable) begin
               mcand_d  = {{WIDTH{1'b0}}, op_a};
               mplier_d = op_b;
               acc_d    = {PW{1'b0}};
               count_d  = {CW{1'b0}};
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end else begin
               busy_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (!mult_enable) begin
               busy_d  = 1'b0;
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               acc_d    = acc_sum_s;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + CW'(1'b1);
               if (count_q == CW'(WIDTH - 1)) begin
                  product_d = acc_sum_s;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = S_DONE;
               end else begin
                  busy_d    = 1'b1;
               end
            end
         end
         S_DONE: begin
            busy_d = 1'b0;
            if (!mult_enable) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               done_d  = 1'b1;
            end
         end
         default: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= {PW{1'b0}};
         mplier_q  <= {WIDTH{1'b0}};
         acc_q     <= {PW{1'b0}};
         count_q   <= {CW{1'b0}};
         product_q <= {PW{1'b0}};
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign product   = product_q;
   assign mult_done = done_q;
   assign busy      = busy_q;

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential shift-and-add unsigned multiplier for the serial 4x4 multiplier datapath.
- Sits between the SIPO deserializer, which supplies the operands, and the PISO serializer, which consumes the product.
- The control FSM drives it with mult_enable, held high for the whole COMPUTE state.
- It returns mult_done, which moves the control FSM to OUTPUT.

Parameters:
- WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mult_enable  input  1  level request from the control FSM; high while in COMPUTE.
- op_a  input  WIDTH  multiplicand from the SIPO; must be stable when mult_enable rises.
- op_b  input  WIDTH  multiplier from the SIPO; must be stable when mult_enable rises.
- product  output  2*WIDTH  registered result; feeds the PISO parallel load.
- mult_done  output  1  registered; high while the result is valid and mult_enable is still high.
- busy  output  1  registered; high while iterations are in progress.

Behaviour:
- Reset: asserting reset (low) forces the following, regardless of clk:
  - state = IDLE
  - product = 0, mult_done = 0, busy = 0
  - internal accumulator, shift registers and counter = 0
- States: IDLE, RUN, DONE (2-bit encoding). Unused encodings go to IDLE.
- IDLE:
  - mult_done = 0, busy = 0.
  - On an edge with mult_enable = 1: latch op_a, zero-extended to 2*WIDTH, into mcand; latch op_b into mplier; clear acc; clear count; set busy = 1; go to RUN.
  - product is not modified in IDLE.
- RUN, one iteration per edge:
  - If mplier[0] = 1, then acc <= acc + mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
  - On the edge that completes iteration WIDTH (count = WIDTH-1): product <= final acc value (including this iteration's add), mult_done <= 1, busy <= 0, go to DONE.
  - No early termination. Latency is fixed for all operand values, including zero.
- Latency: call the edge that samples mult_enable = 1 in IDLE E0. Then product and mult_done are updated at edge E(WIDTH), which is E4 for the default.
- DONE:
  - mult_done stays 1 and product is held as long as mult_enable = 1.
  - On an edge with mult_enable = 0: mult_done <= 0, go to IDLE. product keeps its value so the PISO can still load it.
- Abort: mult_enable = 0 on any edge while in RUN:
  - Go to IDLE, busy <= 0, mult_done stays 0.
  - product is left unchanged (still the previous result); the partial acc is discarded.
- Restart: from DONE, a new operation needs mult_enable to go low for at least one edge. A continuously high mult_enable never retriggers.
- op_a / op_b changes after E0 have no effect on the current operation.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Asserting reset clears product.
- mult_done and busy are never high together.
- Outputs come directly from flops; there are no combinational paths from input to output.

Test Plan:
- Basic product: reset release, op_a = 3, op_b = 5, mult_enable high from E0 -> busy high for E0..E3; at E4 product = 8'h0F, mult_done = 1, busy = 0.
- Max operands: op_a = 15, op_b = 15 -> product = 8'hE1 at E4. Also check op_a = 0, op_b = 9 -> product = 8'h00, mult_done still exactly at E4.
- Hold and release: keep mult_enable high for 3 extra cycles after done -> mult_done and product stable. Then drop mult_enable -> mult_done = 0 one edge later, product still 8'hE1, state IDLE.
- Back-to-back with new operands: after one low cycle, op_a = 9, op_b = 12, mult_enable high -> product = 8'h6C at E4. Also change op_a/op_b at E2 -> result unaffected.
- Abort: start 7*7, drop mult_enable at E2 -> busy = 0, mult_done never asserts, product keeps its prior value (8'h6C). A following 2*6 run gives 8'h0C.
- Async reset: assert reset low between edges during RUN -> product, mult_done and busy go to 0 immediately without a clock edge. After release, a fresh 5*5 run gives 8'h19 at E4.
